// File: rtl/stepped_pair_counter.sv
`default_nettype none
// ============================================================================
// Module   : stepped_pair_counter
// Purpose  : Two W-bit counters x and y that advance in lockstep by fixed
//            per-counter steps (up or down), with load, wrap-or-saturate
//            arithmetic, an accepted-step counter and built-in monitors
//            (linear-invariant check and forbidden-state flag).
// Ports    : clk        rising-edge clock
//            rst        asynchronous active-high reset
//            mode       00 hold, 01 step up, 10 step down, 11 load
//            load_x/y   values loaded when mode=11
//            clr_err    clears err_sticky (a coincident set wins)
//            x, y       registered counters
//            ovf        one-cycle registered pulse: wrap or blocked step
//            step_cnt   saturating count of accepted up/down steps
//            inv_ok     x/y consistent with X_INIT/Y_INIT + STEP*n
//            bad        x==BAD_X and y==BAD_Y
//            err_sticky sticky record of an invariant failure or bad state
// Revision : 1.0 - initial release
// ============================================================================
module stepped_pair_counter #(
  parameter int W        = 8,
  parameter int X_INIT   = 2,
  parameter int Y_INIT   = 0,
  parameter int X_STEP   = 2,
  parameter int Y_STEP   = 1,
  parameter int SATURATE = 0,
  parameter int BAD_X    = 4,
  parameter int BAD_Y    = 0,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  load_x,
  input  logic [W-1:0]  load_y,
  input  logic          clr_err,
  output logic [W-1:0]  x,
  output logic [W-1:0]  y,
  output logic          ovf,
  output logic [CW-1:0] step_cnt,
  output logic          inv_ok,
  output logic          bad,
  output logic          err_sticky
);

  // Parameters reduced to W bits; out-of-range steps simply truncate.
  localparam logic [W-1:0]  C_X_INIT  = W'(X_INIT);
  localparam logic [W-1:0]  C_Y_INIT  = W'(Y_INIT);
  localparam logic [W-1:0]  C_X_STEP  = W'(X_STEP);
  localparam logic [W-1:0]  C_Y_STEP  = W'(Y_STEP);
  localparam logic [W-1:0]  C_BAD_X   = W'(BAD_X);
  localparam logic [W-1:0]  C_BAD_Y   = W'(BAD_Y);
  localparam logic [W-1:0]  C_N_ONE   = W'(1);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
  localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  // One extra bit on each side exposes carry (up) or borrow (down).
  logic [W:0] w_x_up, w_y_up, w_x_dn, w_y_dn;
  logic       w_up_carry, w_dn_borrow;
  logic [W-1:0] w_x_exp, w_y_exp;

  assign w_x_up = {1'b0, x_q} + {1'b0, C_X_STEP};
  assign w_y_up = {1'b0, y_q} + {1'b0, C_Y_STEP};
  assign w_x_dn = {1'b0, x_q} - {1'b0, C_X_STEP};
  assign w_y_dn = {1'b0, y_q} - {1'b0, C_Y_STEP};
  assign w_up_carry  = w_x_up[W] | w_y_up[W];
  assign w_dn_borrow = w_x_dn[W] | w_y_dn[W];

  // Expected position after n net steps, all arithmetic modulo 2^W.
  assign w_x_exp = C_X_INIT + C_X_STEP * n_q;
  assign w_y_exp = C_Y_INIT + C_Y_STEP * n_q;

  assign inv_ok = (x_q == w_x_exp) && (y_q == w_y_exp);
  assign bad    = (x_q == C_BAD_X) && (y_q == C_BAD_Y);

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    n_d   = n_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    case (mode)
      MODE_HOLD: ;
      MODE_UP: begin
        ovf_d = w_up_carry;
        // Both counters move together or neither does (lockstep).
        if (!w_up_carry || (SATURATE == 0)) begin
          x_d = w_x_up[W-1:0];
          y_d = w_y_up[W-1:0];
          n_d = n_q + C_N_ONE;
          if (cnt_q != C_CNT_MAX) cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      MODE_DOWN: begin
        ovf_d = w_dn_borrow;
        if (!w_dn_borrow || (SATURATE == 0)) begin
          x_d = w_x_dn[W-1:0];
          y_d = w_y_dn[W-1:0];
          n_d = n_q - C_N_ONE;
          if (cnt_q != C_CNT_MAX) cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      MODE_LOAD: begin
        x_d = load_x;
        y_d = load_y;
      end
      default: ;
    endcase
  end

  // Monitors look at the current register values; a set beats a clear.
  always_comb begin
    err_d = err_q;
    if (clr_err) err_d = 1'b0;
    if (!inv_ok || bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= C_X_INIT;
      y_q   <= C_Y_INIT;
      n_q   <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      n_q   <= n_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign ovf        = ovf_q;
  assign step_cnt   = cnt_q;
  assign err_sticky = err_q;

endmodule
`default_nettype wire
